arbitro_de_interfaces: RTL and testbench
========================================

// Module: arbitro_de_interfaces
// PURPOSE
//  Sequential arbiter sharing one resource between two user interfaces that present 3-bit priority codes.
//  Grants one interface at a time, with preemption by a strictly higher priority and a hold-time limit for fairness.
//  Reports the active and waiting user codes and flags invalid codes.
//  Sits downstream of the interface code registers; its grant drives the resource mux select.
// PARAMETERS
//  TEMPO_MAX  16  max consecutive grant cycles before a forced handover to a waiting requester (>=2)
//  PREEMPCAO  1   1 = higher-priority requester preempts the holder; 0 = holder keeps grant until release/timeout
//  CONT_W     5   hold-counter width, >= $clog2(TEMPO_MAX+1)
// PORTS
//  clk                  in   1  system clock, rising edge
//  rst_n                in   1  synchronous active-low reset
//  User0                in   3  priority code of interface 0
//  User1                in   3  priority code of interface 1
//  Liberar              in   1  holder releases the resource (one-cycle pulse)
//  Grant                out  2  one-hot grant: [0]=User0, [1]=User1; 00 = none
//  UsuarioAtivo         out  3  code of the current holder; 000 when none
//  UsuarioMenorPrioridade out 3  code of the non-holder while it requests; else 000
//  Troca                out  1  one-cycle pulse on every grant change between users
//  Erro                 out  1  high while in ERRO
// BEHAVIOUR
//  Rank: 101=4 > 011=3 > 001=2 > 110=1; 000 = no request (rank 0); 010/100/111 = invalid.
//  Equal nonzero rank in LIVRE: User0 wins. All outputs are registered; grant latency is 1 cycle.
//  Reset: rst_n low at a clk edge -> state LIVRE, Grant=00, all codes 000, Troca=0, Erro=0, counter=0. Applies mid-grant too.
//  FSM states:
//   LIVRE: both codes 000 -> stay. Otherwise -> CONCEDE0 or CONCEDE1 per rank; counter=0.
//   CONCEDEx, evaluated each cycle in this priority order:
//    1. either code invalid -> ERRO (Grant=00 next cycle).
//    2. Liberar=1 or holder code=000 -> other user requesting ? CONCEDE(other) with Troca=1 : LIVRE.
//    3. PREEMPCAO=1 and rank(other) > rank(holder) -> CONCEDE(other), Troca=1, counter=0.
//    4. counter==TEMPO_MAX-1 and other code != 000 -> CONCEDE(other), Troca=1, counter=0.
//    5. otherwise stay. Counter increments, saturating at TEMPO_MAX-1 while the other user is idle.
//   ERRO: Grant=00, Erro=1; -> LIVRE when both codes are valid (000 allowed) for one sampled cycle.
//  UsuarioAtivo follows the holder's current code each cycle (registered).
//   A holder changing to another valid nonzero code keeps the grant; rank is re-evaluated per step 3.
//  Liberar in LIVRE or ERRO is ignored. Liberar and preemption in the same cycle give the same result as step 2.
//  Troca is never asserted for LIVRE->CONCEDEx or CONCEDEx->LIVRE. Grant never shows 11.
//  A handover is direct CONCEDE0<->CONCEDE1 with no idle gap cycle.
// TESTING
//  T1 rst_n=0 2 cycles with User0=101 -> Grant=00, UsuarioAtivo=000, Erro=0; rst_n=1 -> next cycle Grant=01, UsuarioAtivo=101.
//  T2 LIVRE, User0=110, User1=001 same cycle -> Grant=10, UsuarioAtivo=001, UsuarioMenorPrioridade=110.
//     Tie 011/011 -> Grant=01.
//  T3 Holder User0=001, then User1=101 with PREEMPCAO=1 -> next cycle Grant=10, Troca=1 for one cycle.
//     Same stimulus with PREEMPCAO=0 -> Grant stays 01.
//  T4 User0=011 granted, User1=011 waiting, TEMPO_MAX=16 -> handover to User1 after exactly 16 grant cycles, Troca=1.
//     Repeat with User1=000 -> no handover after 40 cycles.
//  T5 Holder User1, Liberar=1 with User0=000 -> Grant=00 next cycle.
//     Liberar=1 with User0=110 -> Grant=01 next cycle, no 00 gap.
//  T6 User1=111 during a User0 grant -> Grant=00, Erro=1; User1=000 -> LIVRE then Grant=01 one cycle later.
//     Assert rst_n=0 mid-grant -> Grant=00 at the next edge.

Source files
------------

// File: rtl/arbitro_de_interfaces.sv
// ---------------------------------------------------------------------------
// arbitro_de_interfaces
//   Shares one resource between two user interfaces that present 3-bit
//   priority codes. One interface is granted at a time. A holder can be
//   preempted by a strictly higher-ranked requester (PREEMPCAO=1). A holder
//   is also forced to hand over after TEMPO_MAX consecutive grant cycles
//   when the other interface is waiting. Invalid codes park the arbiter in
//   an error state until both codes are valid again.
//
// Ports
//   clk                     in   1  system clock, rising edge
//   rst_n                   in   1  synchronous active-low reset
//   User0                   in   3  priority code of interface 0
//   User1                   in   3  priority code of interface 1
//   Liberar                 in   1  holder releases the resource (pulse)
//   Grant                   out  2  one-hot grant, [0]=User0 [1]=User1
//   UsuarioAtivo            out  3  current holder code, 000 when none
//   UsuarioMenorPrioridade  out  3  waiting non-holder code, else 000
//   Troca                   out  1  one-cycle pulse on a user-to-user handover
//   Erro                    out  1  high while in the error state
//
// Code ranking: 101=4 > 011=3 > 001=2 > 110=1, 000 = idle,
// 010/100/111 = invalid. All outputs are registered.
// ---------------------------------------------------------------------------
module arbitro_de_interfaces #(
  parameter int unsigned TEMPO_MAX = 16,
  parameter int unsigned PREEMPCAO = 1,
  parameter int unsigned CONT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] User0,
  input  logic [2:0] User1,
  input  logic       Liberar,
  output logic [1:0] Grant,
  output logic [2:0] UsuarioAtivo,
  output logic [2:0] UsuarioMenorPrioridade,
  output logic       Troca,
  output logic       Erro
);

  localparam logic [CONT_W-1:0] CNT_LIM = CONT_W'(TEMPO_MAX - 1);

  typedef enum logic [1:0] {
    ST_LIVRE = 2'd0,
    ST_CONC0 = 2'd1,
    ST_CONC1 = 2'd2,
    ST_ERRO  = 2'd3
  } state_t;

  state_t            r_state;
  logic [CONT_W-1:0] r_cnt;

  logic [2:0] w_rank0;
  logic [2:0] w_rank1;
  logic       w_inval;
  logic       w_pede0;
  logic       w_pede1;

  // Rank of a code; idle and invalid codes both map to 0
  function automatic logic [2:0] f_rank(input logic [2:0] code);
    logic [2:0] rank;
    case (code)
      3'b101:  rank = 3'd4;
      3'b011:  rank = 3'd3;
      3'b001:  rank = 3'd2;
      3'b110:  rank = 3'd1;
      default: rank = 3'd0;
    endcase
    return rank;
  endfunction

  // Idle (000) counts as a valid code
  function automatic logic f_valido(input logic [2:0] code);
    logic ok;
    case (code)
      3'b000, 3'b001, 3'b011, 3'b101, 3'b110: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign w_rank0 = f_rank(User0);
  assign w_rank1 = f_rank(User1);
  assign w_inval = !f_valido(User0) || !f_valido(User1);
  assign w_pede0 = (User0 != 3'b000);
  assign w_pede1 = (User1 != 3'b000);

  // Arbitration FSM; outputs are registered alongside the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state                <= ST_LIVRE;
      r_cnt                  <= '0;
      Grant                  <= 2'b00;
      UsuarioAtivo           <= 3'b000;
      UsuarioMenorPrioridade <= 3'b000;
      Troca                  <= 1'b0;
      Erro                   <= 1'b0;
    end else begin
      Troca <= 1'b0;
      case (r_state)
        ST_LIVRE: begin
          if (w_inval) begin
            r_state <= ST_ERRO;
            Erro    <= 1'b1;
          end else if (w_pede0 || w_pede1) begin
            // Ties go to User0
            r_cnt <= '0;
            if (w_rank0 >= w_rank1) begin
              r_state                <= ST_CONC0;
              Grant                  <= 2'b01;
              UsuarioAtivo           <= User0;
              UsuarioMenorPrioridade <= User1;
            end else begin
              r_state                <= ST_CONC1;
              Grant                  <= 2'b10;
              UsuarioAtivo           <= User1;
              UsuarioMenorPrioridade <= User0;
            end
          end
        end

        ST_CONC0: begin
          if (w_inval) begin
            r_state                <= ST_ERRO;
            Grant                  <= 2'b00;
            UsuarioAtivo           <= 3'b000;
            UsuarioMenorPrioridade <= 3'b000;
            Erro                   <= 1'b1;
          end else if ((Liberar || !w_pede0) && !w_pede1) begin
            r_state                <= ST_LIVRE;
            Grant                  <= 2'b00;
            UsuarioAtivo           <= 3'b000;
            UsuarioMenorPrioridade <= 3'b000;
          end else if (Liberar || !w_pede0 ||
                       ((PREEMPCAO != 0) && (w_rank1 > w_rank0)) ||
                       ((r_cnt == CNT_LIM) && w_pede1)) begin
            // Release, preemption or hold-time expiry: hand over directly
            r_state                <= ST_CONC1;
            r_cnt                  <= '0;
            Grant                  <= 2'b10;
            UsuarioAtivo           <= User1;
            UsuarioMenorPrioridade <= User0;
            Troca                  <= 1'b1;
          end else begin
            UsuarioAtivo           <= User0;
            UsuarioMenorPrioridade <= User1;
            if (r_cnt != CNT_LIM) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        ST_CONC1: begin
          if (w_inval) begin
            r_state                <= ST_ERRO;
            Grant                  <= 2'b00;
            UsuarioAtivo           <= 3'b000;
            UsuarioMenorPrioridade <= 3'b000;
            Erro                   <= 1'b1;
          end else if ((Liberar || !w_pede1) && !w_pede0) begin
            r_state                <= ST_LIVRE;
            Grant                  <= 2'b00;
            UsuarioAtivo           <= 3'b000;
            UsuarioMenorPrioridade <= 3'b000;
          end else if (Liberar || !w_pede1 ||
                       ((PREEMPCAO != 0) && (w_rank0 > w_rank1)) ||
                       ((r_cnt == CNT_LIM) && w_pede0)) begin
            r_state                <= ST_CONC0;
            r_cnt                  <= '0;
            Grant                  <= 2'b01;
            UsuarioAtivo           <= User0;
            UsuarioMenorPrioridade <= User1;
            Troca                  <= 1'b1;
          end else begin
            UsuarioAtivo           <= User1;
            UsuarioMenorPrioridade <= User0;
            if (r_cnt != CNT_LIM) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        ST_ERRO: begin
          // Leave only once both codes are valid again
          if (!w_inval) begin
            r_state <= ST_LIVRE;
            Erro    <= 1'b0;
          end
        end

        default: begin
          r_state                <= ST_LIVRE;
          Grant                  <= 2'b00;
          UsuarioAtivo           <= 3'b000;
          UsuarioMenorPrioridade <= 3'b000;
          Erro                   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_de_interfaces.sv
// ---------------------------------------------------------------------------
// tb_arbitro_de_interfaces
//   Self-checking bench for arbitro_de_interfaces. Two instances share the
//   same stimulus: u_dut_p preempts (PREEMPCAO=1), u_dut_n does not.
//   Directed scenario tasks check fixed expectations; a randomized phase
//   checks both instances against a behavioural holder/counter model.
// ---------------------------------------------------------------------------
module tb_arbitro_de_interfaces;

  localparam int TMAX = 16;

  logic       clk;
  logic       rst_n;
  logic [2:0] u0, u1;
  logic       lib;

  logic [1:0] g_p, g_n;
  logic [2:0] ua_p, ua_n, ump_p, ump_n;
  logic       tr_p, tr_n, er_p, er_n;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state, index 0 = preempting instance, 1 = non-preempting
  int rank_tab [8] = '{0, 2, -1, 3, -1, 4, 1, -1};
  int m_hold [2]   = '{-1, -1};
  int m_cnt  [2]   = '{0, 0};
  bit m_err  [2]   = '{1'b0, 1'b0};
  bit m_tr   [2]   = '{1'b0, 1'b0};
  int e_g    [2];
  int e_ua   [2];
  int e_ump  [2];

  arbitro_de_interfaces #(.TEMPO_MAX(TMAX), .PREEMPCAO(1), .CONT_W(5)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .User0(u0), .User1(u1), .Liberar(lib),
    .Grant(g_p), .UsuarioAtivo(ua_p), .UsuarioMenorPrioridade(ump_p),
    .Troca(tr_p), .Erro(er_p)
  );

  arbitro_de_interfaces #(.TEMPO_MAX(TMAX), .PREEMPCAO(0), .CONT_W(5)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .User0(u0), .User1(u1), .Liberar(lib),
    .Grant(g_n), .UsuarioAtivo(ua_n), .UsuarioMenorPrioridade(ump_n),
    .Troca(tr_n), .Erro(er_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: who holds the resource, how long, and whether codes are broken
  function automatic void m_step(input int k);
    int c [2];
    int r [2];
    bit inval;
    int h;
    int o;
    bit pre;
    pre   = (k == 0);
    c[0]  = int'(u0);
    c[1]  = int'(u1);
    r[0]  = rank_tab[u0];
    r[1]  = rank_tab[u1];
    inval = (r[0] < 0) || (r[1] < 0);
    m_tr[k] = 1'b0;
    if (!rst_n) begin
      m_hold[k] = -1; m_err[k] = 1'b0; m_cnt[k] = 0;
    end else if (m_err[k]) begin
      if (!inval) m_err[k] = 1'b0;
    end else if (m_hold[k] < 0) begin
      if (inval) m_err[k] = 1'b1;
      else if (r[0] > 0 || r[1] > 0) begin
        m_hold[k] = (r[0] >= r[1]) ? 0 : 1;
        m_cnt[k]  = 0;
      end
    end else begin
      h = m_hold[k];
      o = 1 - h;
      if (inval) begin
        m_err[k] = 1'b1; m_hold[k] = -1;
      end else if (lib || c[h] == 0) begin
        if (c[o] != 0) begin
          m_hold[k] = o; m_tr[k] = 1'b1; m_cnt[k] = 0;
        end else m_hold[k] = -1;
      end else if ((pre && r[o] > r[h]) || (m_cnt[k] == TMAX - 1 && c[o] != 0)) begin
        m_hold[k] = o; m_tr[k] = 1'b1; m_cnt[k] = 0;
      end else if (m_cnt[k] < TMAX - 1) begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
    h = m_hold[k];
    e_g[k]   = (h < 0) ? 0 : (1 << h);
    e_ua[k]  = (h < 0) ? 0 : c[h];
    e_ump[k] = (h < 0) ? 0 : c[1 - h];
  endfunction

  // One clock: model follows the same edge, outputs sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    m_step(0);
    m_step(1);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; u0 = 3'b000; u1 = 3'b000; lib = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [2:0] pick_code();
    logic [2:0] code;
    case ($urandom_range(0, 9))
      0, 1:    code = 3'b000;
      2:       code = 3'b001;
      3, 4:    code = 3'b011;
      5:       code = 3'b101;
      6:       code = 3'b110;
      7:       code = 3'b001;
      8:       code = 3'b101;
      default: begin
        case ($urandom_range(0, 2))
          0:       code = 3'b010;
          1:       code = 3'b100;
          default: code = 3'b111;
        endcase
      end
    endcase
    return code;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; u0 = 3'b101; u1 = 3'b000; lib = 1'b0;
    tick();
    tick();
    n_vec++; if (g_p !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b want 00", g_p); end
    n_vec++; if (ua_p !== 3'b000) begin n_err++; $display("FAIL reset_ativo: got %b want 000", ua_p); end
    n_vec++; if (er_p !== 1'b0 || tr_p !== 1'b0) begin n_err++; $display("FAIL reset_flags: got erro=%b troca=%b want 0/0", er_p, tr_p); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (g_p !== 2'b01) begin n_err++; $display("FAIL reset_release_grant: got %b want 01", g_p); end
    n_vec++; if (ua_p !== 3'b101) begin n_err++; $display("FAIL reset_release_ativo: got %b want 101", ua_p); end
  endtask

  task automatic test_prioridade();
    do_reset();
    u0 = 3'b110; u1 = 3'b001;
    tick();
    n_vec++; if (g_p !== 2'b10) begin n_err++; $display("FAIL rank_grant: got %b want 10", g_p); end
    n_vec++; if (ua_p !== 3'b001) begin n_err++; $display("FAIL rank_ativo: got %b want 001", ua_p); end
    n_vec++; if (ump_p !== 3'b110) begin n_err++; $display("FAIL rank_menor: got %b want 110", ump_p); end
    do_reset();
    u0 = 3'b011; u1 = 3'b011;
    tick();
    n_vec++; if (g_p !== 2'b01 || g_n !== 2'b01) begin n_err++; $display("FAIL tie_grant: got p=%b n=%b want 01", g_p, g_n); end
  endtask

  task automatic test_preempcao();
    do_reset();
    u0 = 3'b001; u1 = 3'b000;
    tick();
    u1 = 3'b101;
    tick();
    n_vec++; if (g_p !== 2'b10 || tr_p !== 1'b1) begin n_err++; $display("FAIL preempt_on: got grant=%b troca=%b want 10/1", g_p, tr_p); end
    n_vec++; if (g_n !== 2'b01 || tr_n !== 1'b0) begin n_err++; $display("FAIL preempt_off: got grant=%b troca=%b want 01/0", g_n, tr_n); end
    tick();
    n_vec++; if (g_p !== 2'b10 || tr_p !== 1'b0) begin n_err++; $display("FAIL preempt_pulse: got grant=%b troca=%b want 10/0", g_p, tr_p); end
  endtask

  task automatic test_timeout();
    int cycles;
    bit moved;
    do_reset();
    u0 = 3'b011; u1 = 3'b011;
    tick();
    cycles = (g_p === 2'b01) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (g_p === 2'b01) cycles++;
      else break;
    end
    n_vec++; if (cycles != TMAX) begin n_err++; $display("FAIL timeout_len: got %0d grant cycles want %0d", cycles, TMAX); end
    n_vec++; if (g_p !== 2'b10 || tr_p !== 1'b1) begin n_err++; $display("FAIL timeout_handover: got grant=%b troca=%b want 10/1", g_p, tr_p); end

    do_reset();
    u0 = 3'b011; u1 = 3'b000;
    tick();
    moved = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (g_p !== 2'b01 || tr_p !== 1'b0) moved = 1'b1;
    end
    n_vec++; if (moved) begin n_err++; $display("FAIL timeout_idle: got grant=%b want steady 01", g_p); end
    // Saturated counter: a newly arriving equal-rank requester takes over at once
    u1 = 3'b011;
    tick();
    n_vec++; if (g_p !== 2'b10 || tr_p !== 1'b1) begin n_err++; $display("FAIL timeout_saturated: got grant=%b troca=%b want 10/1", g_p, tr_p); end
  endtask

  task automatic test_liberar();
    do_reset();
    u0 = 3'b000; u1 = 3'b001;
    tick();
    lib = 1'b1;
    tick();
    lib = 1'b0;
    n_vec++; if (g_p !== 2'b00 || tr_p !== 1'b0) begin n_err++; $display("FAIL release_idle: got grant=%b troca=%b want 00/0", g_p, tr_p); end
    do_reset();
    u0 = 3'b000; u1 = 3'b001;
    tick();
    u0 = 3'b110; lib = 1'b1;
    tick();
    lib = 1'b0;
    n_vec++; if (g_p !== 2'b01 || tr_p !== 1'b1) begin n_err++; $display("FAIL release_handover: got grant=%b troca=%b want 01/1", g_p, tr_p); end
    n_vec++; if (ua_p !== 3'b110 || ump_p !== 3'b001) begin n_err++; $display("FAIL release_codes: got ativo=%b menor=%b want 110/001", ua_p, ump_p); end
  endtask

  task automatic test_erro();
    do_reset();
    u0 = 3'b101; u1 = 3'b000;
    tick();
    u1 = 3'b111;
    tick();
    n_vec++; if (g_p !== 2'b00 || er_p !== 1'b1) begin n_err++; $display("FAIL erro_enter: got grant=%b erro=%b want 00/1", g_p, er_p); end
    u1 = 3'b000;
    tick();
    n_vec++; if (g_p !== 2'b00 || er_p !== 1'b0) begin n_err++; $display("FAIL erro_exit: got grant=%b erro=%b want 00/0", g_p, er_p); end
    tick();
    n_vec++; if (g_p !== 2'b01) begin n_err++; $display("FAIL erro_regrant: got %b want 01", g_p); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++; if (g_p !== 2'b00 || ua_p !== 3'b000) begin n_err++; $display("FAIL reset_midgrant: got grant=%b ativo=%b want 00/000", g_p, ua_p); end
  endtask

  task automatic test_random();
    logic [9:0] got;
    logic [9:0] exp;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) u0 = pick_code();
      if ($urandom_range(0, 3) == 0) u1 = pick_code();
      lib   = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        got = (k == 0) ? {g_p, ua_p, ump_p, tr_p, er_p} : {g_n, ua_n, ump_n, tr_n, er_n};
        exp = {2'(e_g[k]), 3'(e_ua[k]), 3'(e_ump[k]), m_tr[k], m_err[k]};
        n_vec++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL random_%0d inst=%0d u0=%b u1=%b lib=%b: got g/ua/ump/tr/er=%b want %b",
                   i, k, u0, u1, lib, got, exp);
        end
      end
    end
    rst_n = 1'b1;
    lib   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; u0 = 3'b000; u1 = 3'b000; lib = 1'b0;
    test_reset();
    test_prioridade();
    test_preempcao();
    test_timeout();
    test_liberar();
    test_erro();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
